// File: rtl/ccd_line_fifo_if.sv
// AXI4-Stream bundle used for both the pixel input and the buffered output of ccd_line_fifo.
// The input side of the converter has no backpressure, so the FIFO ties its tready high.
interface ccd_line_fifo_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tuser;
   logic                  tlast;
   logic                  tready;

   modport master (output tdata, tvalid, tuser, tlast, input tready);
   modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/ccd_line_fifo.sv
// Line-granular AXI4-Stream FIFO behind a CCD converter that cannot be stalled.
// Whole lines are admitted or discarded; SOF from dropped lines is carried forward.
module ccd_line_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12,
   parameter int LINE_LEN   = 2048
) (
   input  logic                pixel_clk,
   input  logic                rst_n,
   ccd_line_fifo_if.slave      s_axis,
   ccd_line_fifo_if.master     m_axis,
   output logic [ADDR_WIDTH:0] fifo_level,
   output logic [15:0]         drop_cnt,
   output logic                line_err
);
   localparam int DEPTH  = 1 << ADDR_WIDTH;
   localparam int WORD_W = DATA_WIDTH + 2;
   localparam int CNT_W  = $clog2(LINE_LEN + 1);
   localparam logic [ADDR_WIDTH:0] ADMIT_MAX  = (ADDR_WIDTH + 1)'(DEPTH - LINE_LEN);
   localparam logic [CNT_W-1:0]    LINE_LEN_C = CNT_W'(LINE_LEN);

   typedef enum logic [1:0] {RESYNC, WAIT_SOL, ACCEPT, DROP} wr_state_e;

   wr_state_e             state_q, state_d;
   logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
   logic                  pending_sof_q, pending_sof_d;
   logic [15:0]           drop_cnt_q, drop_cnt_d;
   logic                  line_err_q, line_err_d;
   logic                  wr_en_q, wr_en_d;
   logic [WORD_W-1:0]     wr_word_q, wr_word_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
   logic [ADDR_WIDTH:0]   level_q, level_d;
   logic                  out_valid_q, out_valid_d;
   logic [WORD_W-1:0]     out_word_q, out_word_d;
   logic [WORD_W-1:0]     mem [DEPTH];

   logic start_line;
   logic admit_ok;
   logic xfer;
   logic load;

   // Level counts a beat from the moment it is accepted, so admission sees pipelined beats too.
   assign admit_ok = (level_q <= ADMIT_MAX);
   assign xfer     = out_valid_q & m_axis.tready;
   assign load     = (ram_cnt_q != '0) && (!out_valid_q || m_axis.tready);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      beat_cnt_d    = beat_cnt_q;
      pending_sof_d = pending_sof_q;
      drop_cnt_d    = drop_cnt_q;
      line_err_d    = 1'b0;
      wr_en_d       = 1'b0;
      wr_word_d     = wr_word_q;
      start_line    = 1'b0;

      if (s_axis.tvalid) begin
         unique case (state_q)
            RESYNC: begin
               if (s_axis.tuser)      start_line = 1'b1;
               else if (s_axis.tlast) state_d    = WAIT_SOL;
            end
            WAIT_SOL: start_line = 1'b1;
            ACCEPT: begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               wr_en_d    = 1'b1;
               wr_word_d  = {s_axis.tuser, s_axis.tlast, s_axis.tdata};
               if (s_axis.tlast) begin
                  state_d = WAIT_SOL;
               end else if (beat_cnt_d == LINE_LEN_C) begin
                  // Truncate: close the stored line here and discard the rest of it.
                  wr_word_d[DATA_WIDTH] = 1'b1;
                  line_err_d            = 1'b1;
                  state_d               = DROP;
               end
            end
            DROP: begin
               pending_sof_d = pending_sof_q | s_axis.tuser;
               if (s_axis.tlast) state_d = WAIT_SOL;
            end
         endcase

         if (start_line) begin
            if (admit_ok) begin
               wr_en_d       = 1'b1;
               wr_word_d     = {s_axis.tuser | pending_sof_q, s_axis.tlast, s_axis.tdata};
               pending_sof_d = 1'b0;
               beat_cnt_d    = CNT_W'(1);
               state_d       = s_axis.tlast ? WAIT_SOL : ACCEPT;
            end else begin
               if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
               pending_sof_d = pending_sof_q | s_axis.tuser;
               state_d       = s_axis.tlast ? WAIT_SOL : DROP;
            end
         end
      end
   end

   always_comb begin
      out_valid_d = load | (out_valid_q & ~xfer);
      out_word_d  = load ? mem[rd_ptr_q] : out_word_q;
      rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(load);
      wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(wr_en_q);
      ram_cnt_d   = ram_cnt_q + (ADDR_WIDTH + 1)'(wr_en_q) - (ADDR_WIDTH + 1)'(load);
      level_d     = level_q + (ADDR_WIDTH + 1)'(wr_en_d) - (ADDR_WIDTH + 1)'(xfer);
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RESYNC;
         beat_cnt_q    <= '0;
         pending_sof_q <= 1'b0;
         drop_cnt_q    <= '0;
         line_err_q    <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_word_q     <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         ram_cnt_q     <= '0;
         level_q       <= '0;
         out_valid_q   <= 1'b0;
         out_word_q    <= '0;
      end else begin
         state_q       <= state_d;
         beat_cnt_q    <= beat_cnt_d;
         pending_sof_q <= pending_sof_d;
         drop_cnt_q    <= drop_cnt_d;
         line_err_q    <= line_err_d;
         wr_en_q       <= wr_en_d;
         wr_word_q     <= wr_word_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         ram_cnt_q     <= ram_cnt_d;
         level_q       <= level_d;
         out_valid_q   <= out_valid_d;
         out_word_q    <= out_word_d;
      end
   end

   // NOTE: the RAM is not reset; pointers and counts define which words are valid.
   always_ff @(posedge pixel_clk) begin
      if (wr_en_q) mem[wr_ptr_q] <= wr_word_q;
   end

   assign s_axis.tready = 1'b1;
   assign m_axis.tvalid = out_valid_q;
   assign m_axis.tuser  = out_word_q[DATA_WIDTH+1];
   assign m_axis.tlast  = out_word_q[DATA_WIDTH];
   assign m_axis.tdata  = out_word_q[DATA_WIDTH-1:0];
   assign fifo_level    = level_q;
   assign drop_cnt      = drop_cnt_q;
   assign line_err      = line_err_q;
endmodule

// File: tb/tb_ccd_line_fifo.sv
`timescale 1ns/1ps
// Directed bench for ccd_line_fifo: flow, backpressure drops, SOF carry, overlong lines, resets.
module tb_ccd_line_fifo;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int LL = 2048;

  logic          pixel_clk = 1'b0;
  logic          rst_n     = 1'b0;
  logic [AW:0]   fifo_level;
  logic [15:0]   drop_cnt;
  logic          line_err;

  ccd_line_fifo_if #(.DATA_WIDTH(DW)) s_axis ();
  ccd_line_fifo_if #(.DATA_WIDTH(DW)) m_axis ();

  ccd_line_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_LEN(LL)) dut (
    .pixel_clk  (pixel_clk),
    .rst_n      (rst_n),
    .s_axis     (s_axis),
    .m_axis     (m_axis),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt),
    .line_err   (line_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  int            total = 0;
  int            bad   = 0;
  int unsigned   cyc   = 0;
  int unsigned   mark_cyc = 0;
  int unsigned   err_pulses = 0;
  int unsigned   err_cyc = 0;
  logic [DW+1:0] out_q[$];
  int unsigned   out_cyc[$];
  logic [DW+1:0] exp_q[$];

  always @(posedge pixel_clk) cyc <= cyc + 1;

  // Transfers are recorded on the falling edge, ahead of the rising edge that completes them.
  always @(negedge pixel_clk) begin
    if (m_axis.tvalid && m_axis.tready) begin
      out_q.push_back({m_axis.tuser, m_axis.tlast, m_axis.tdata});
      out_cyc.push_back(cyc);
    end
    if (line_err) begin
      err_pulses = err_pulses + 1;
      err_cyc    = cyc;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic u, input logic l);
    @(posedge pixel_clk);
    #1;
    s_axis.tvalid = v;
    s_axis.tdata  = d;
    s_axis.tuser  = u;
    s_axis.tlast  = l;
  endtask

  task automatic send_line(input int len, input logic sof, input logic [DW-1:0] base, input int mark);
    for (int i = 0; i < len; i++) begin
      drive(1'b1, base + DW'(i), sof && (i == 0), i == len - 1);
      if (i == mark) mark_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic expect_line(input int len, input logic sof, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) exp_q.push_back({sof && (i == 0), i == len - 1, base + DW'(i)});
  endtask

  task automatic wait_out(input int base, input int n, input int budget);
    for (int i = 0; i < budget && (out_q.size() - base) < n; i++) @(posedge pixel_clk);
    repeat (10) @(posedge pixel_clk);
    #1;
  endtask

  task automatic test_reset();
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tuser = 1'b0; s_axis.tlast = 1'b0;
    m_axis.tready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1;
    total++;
    if ({m_axis.tvalid, m_axis.tuser, m_axis.tlast, m_axis.tdata} !== '0) begin
      bad++; $display("FAIL reset_m_axis: got %h expected 0", {m_axis.tvalid, m_axis.tuser, m_axis.tlast, m_axis.tdata});
    end
    total++;
    if (fifo_level !== '0) begin bad++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    total++;
    if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    total++;
    if (line_err !== 1'b0) begin bad++; $display("FAIL reset_line_err: got %b expected 0", line_err); end
    rst_n = 1'b1;
    idle(3);
    total++;
    if (m_axis.tvalid !== 1'b0 || fifo_level !== '0) begin
      bad++; $display("FAIL reset_idle: got valid=%b level=%0d expected 0/0", m_axis.tvalid, fifo_level);
    end
  endtask

  task automatic test_basic();
    int base, got, nb, first, lat;
    int unsigned first_cyc;
    base = out_q.size();
    exp_q.delete();
    m_axis.tready = 1'b1;
    drive(1'b1, 8'h55, 1'b0, 1'b1);
    send_line(LL, 1'b1, 8'h00, 0);
    first_cyc = mark_cyc;
    send_line(LL, 1'b0, 8'h00, -1);
    send_line(LL, 1'b0, 8'h00, -1);
    idle(1);
    wait_out(base, 3 * LL, 4 * LL);
    expect_line(LL, 1'b1, 8'h00); expect_line(LL, 1'b0, 8'h00); expect_line(LL, 1'b0, 8'h00);
    got = out_q.size() - base;
    total++;
    if (got !== exp_q.size()) begin bad++; $display("FAIL basic_beats: got %0d expected %0d", got, exp_q.size()); end
    nb = 0; first = 0;
    for (int i = 0; i < exp_q.size() && i < got; i++)
      if (out_q[base+i] !== exp_q[i]) begin if (nb == 0) first = i; nb++; end
    total++;
    if (nb !== 0) begin
      bad++; $display("FAIL basic_stream: %0d beats wrong, first %0d got %h expected %h", nb, first, out_q[base+first], exp_q[first]);
    end
    lat = (got > 0) ? int'(out_cyc[base]) - int'(first_cyc) : -1;
    total++;
    if (lat !== 3) begin bad++; $display("FAIL basic_latency: got %0d expected 3 cycles from drive to output", lat); end
    total++;
    if (drop_cnt !== 16'd0) begin bad++; $display("FAIL basic_drop_cnt: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_backpressure();
    int base, got, nb, first, nlast;
    base = out_q.size();
    exp_q.delete();
    m_axis.tready = 1'b0;
    send_line(LL, 1'b1, 8'h00, -1);
    send_line(LL, 1'b0, 8'h00, -1);
    send_line(LL, 1'b1, 8'h00, -1);
    idle(5);
    total++;
    if (fifo_level !== 13'd4096) begin bad++; $display("FAIL bp_level_full: got %0d expected 4096", fifo_level); end
    total++;
    if (drop_cnt !== 16'd1) begin bad++; $display("FAIL bp_drop_cnt: got %0d expected 1", drop_cnt); end
    total++;
    if ({m_axis.tvalid, m_axis.tuser, m_axis.tlast, m_axis.tdata} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      bad++; $display("FAIL bp_head: got %h expected %h", {m_axis.tvalid, m_axis.tuser, m_axis.tlast, m_axis.tdata}, {1'b1, 1'b1, 1'b0, 8'h00});
    end
    idle(20);
    total++;
    if ({m_axis.tvalid, m_axis.tuser, m_axis.tlast, m_axis.tdata} !== {1'b1, 1'b1, 1'b0, 8'h00} || out_q.size() !== base) begin
      bad++; $display("FAIL bp_hold: got %h with %0d transfers expected %h with 0", {m_axis.tvalid, m_axis.tuser, m_axis.tlast, m_axis.tdata}, out_q.size() - base, {1'b1, 1'b1, 1'b0, 8'h00});
    end
    m_axis.tready = 1'b1;
    wait_out(base, 2 * LL, 3 * LL);
    expect_line(LL, 1'b1, 8'h00); expect_line(LL, 1'b0, 8'h00);
    got = out_q.size() - base;
    total++;
    if (got !== exp_q.size()) begin bad++; $display("FAIL bp_beats: got %0d expected %0d", got, exp_q.size()); end
    nb = 0; first = 0; nlast = 0;
    for (int i = 0; i < got; i++) if (out_q[base+i][DW]) nlast++;
    for (int i = 0; i < exp_q.size() && i < got; i++)
      if (out_q[base+i] !== exp_q[i]) begin if (nb == 0) first = i; nb++; end
    total++;
    if (nb !== 0) begin
      bad++; $display("FAIL bp_stream: %0d beats wrong, first %0d got %h expected %h", nb, first, out_q[base+first], exp_q[first]);
    end
    total++;
    if (nlast !== 2) begin bad++; $display("FAIL bp_tlast_count: got %0d expected 2", nlast); end
    total++;
    if (fifo_level !== '0) begin bad++; $display("FAIL bp_level_empty: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_sof();
    int base, got, nb, first;
    base = out_q.size();
    exp_q.delete();
    send_line(8, 1'b0, 8'h20, -1);
    send_line(8, 1'b0, 8'h30, -1);
    idle(1);
    wait_out(base, 16, 100);
    expect_line(8, 1'b1, 8'h20); expect_line(8, 1'b0, 8'h30);
    got = out_q.size() - base;
    total++;
    if (got !== exp_q.size()) begin bad++; $display("FAIL sof_beats: got %0d expected %0d", got, exp_q.size()); end
    nb = 0; first = 0;
    for (int i = 0; i < exp_q.size() && i < got; i++)
      if (out_q[base+i] !== exp_q[i]) begin if (nb == 0) first = i; nb++; end
    total++;
    if (nb !== 0) begin
      bad++; $display("FAIL sof_stream: %0d beats wrong, first %0d got %h expected %h", nb, first, out_q[base+first], exp_q[first]);
    end
  endtask

  task automatic test_overlong();
    int base, got, nb, first;
    int unsigned err_base, bad_cyc;
    base = out_q.size();
    err_base = err_pulses;
    exp_q.delete();
    send_line(LL + 2, 1'b1, 8'h00, LL - 1);
    bad_cyc = mark_cyc;
    send_line(8, 1'b0, 8'hA0, -1);
    idle(1);
    wait_out(base, LL + 8, 3 * LL);
    expect_line(LL, 1'b1, 8'h00); expect_line(8, 1'b0, 8'hA0);
    got = out_q.size() - base;
    total++;
    if (got !== exp_q.size()) begin bad++; $display("FAIL long_beats: got %0d expected %0d", got, exp_q.size()); end
    nb = 0; first = 0;
    for (int i = 0; i < exp_q.size() && i < got; i++)
      if (out_q[base+i] !== exp_q[i]) begin if (nb == 0) first = i; nb++; end
    total++;
    if (nb !== 0) begin
      bad++; $display("FAIL long_stream: %0d beats wrong, first %0d got %h expected %h", nb, first, out_q[base+first], exp_q[first]);
    end
    total++;
    if (err_pulses - err_base !== 1) begin bad++; $display("FAIL long_err_pulses: got %0d expected 1", err_pulses - err_base); end
    total++;
    if (err_cyc !== bad_cyc + 1) begin bad++; $display("FAIL long_err_timing: got cycle %0d expected %0d", err_cyc, bad_cyc + 1); end
    total++;
    if (drop_cnt !== 16'd1) begin bad++; $display("FAIL long_drop_cnt: got %0d expected 1", drop_cnt); end
  endtask

  task automatic test_resync();
    int base, got, nb, first;
    base = out_q.size();
    exp_q.delete();
    m_axis.tready = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < LL; i++) begin
      drive(1'b1, DW'(i), i == 0, i == LL - 1);
      if (i == LL - 1000) rst_n = 1'b1;
    end
    send_line(16, 1'b1, 8'h40, -1);
    idle(1);
    wait_out(base, 16, 200);
    expect_line(16, 1'b1, 8'h40);
    got = out_q.size() - base;
    total++;
    if (got !== exp_q.size()) begin bad++; $display("FAIL resync_beats: got %0d expected %0d", got, exp_q.size()); end
    nb = 0; first = 0;
    for (int i = 0; i < exp_q.size() && i < got; i++)
      if (out_q[base+i] !== exp_q[i]) begin if (nb == 0) first = i; nb++; end
    total++;
    if (nb !== 0) begin
      bad++; $display("FAIL resync_stream: %0d beats wrong, first %0d got %h expected %h", nb, first, out_q[base+first], exp_q[first]);
    end
    total++;
    if (drop_cnt !== 16'd0) begin bad++; $display("FAIL resync_drop_cnt: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_async_reset();
    int base, got, nb, first;
    m_axis.tready = 1'b0;
    send_line(LL, 1'b1, 8'h00, -1);
    send_line(952, 1'b0, 8'h00, -1);
    idle(5);
    total++;
    if (fifo_level !== 13'd3000) begin bad++; $display("FAIL arst_level_before: got %0d expected 3000", fifo_level); end
    @(posedge pixel_clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({m_axis.tvalid, m_axis.tuser, m_axis.tlast, m_axis.tdata} !== '0) begin
      bad++; $display("FAIL arst_m_axis: got %h expected 0", {m_axis.tvalid, m_axis.tuser, m_axis.tlast, m_axis.tdata});
    end
    total++;
    if (fifo_level !== '0) begin bad++; $display("FAIL arst_level: got %0d expected 0", fifo_level); end
    @(posedge pixel_clk);
    #1;
    rst_n = 1'b1;
    m_axis.tready = 1'b1;
    base = out_q.size();
    idle(20);
    total++;
    if (out_q.size() !== base || fifo_level !== '0 || m_axis.tvalid !== 1'b0) begin
      bad++; $display("FAIL arst_quiet: got %0d beats level=%0d valid=%b expected 0/0/0", out_q.size() - base, fifo_level, m_axis.tvalid);
    end
    exp_q.delete();
    send_line(4, 1'b1, 8'h10, -1);
    idle(1);
    wait_out(base, 4, 50);
    expect_line(4, 1'b1, 8'h10);
    got = out_q.size() - base;
    total++;
    if (got !== exp_q.size()) begin bad++; $display("FAIL arst_beats: got %0d expected %0d", got, exp_q.size()); end
    nb = 0; first = 0;
    for (int i = 0; i < exp_q.size() && i < got; i++)
      if (out_q[base+i] !== exp_q[i]) begin if (nb == 0) first = i; nb++; end
    total++;
    if (nb !== 0) begin
      bad++; $display("FAIL arst_stream: %0d beats wrong, first %0d got %h expected %h", nb, first, out_q[base+first], exp_q[first]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_sof();
    test_overlong();
    test_resync();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ccd_line_fifo.md
# ccd_line_fifo

Line-granular AXI4-Stream FIFO placed directly downstream of the CCD-to-AXIS converter, which cannot accept backpressure. It buffers pixel beats and presents them on a standard ready/valid master port. Admission is decided per line: a whole line is either stored or discarded, so every line leaving the block is complete. SOF (tuser) is preserved across dropped lines, and drop and error events are reported.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width.
- ADDR_WIDTH, 12, FIFO RAM depth = 2**ADDR_WIDTH entries (4096).
- LINE_LEN, 2048, maximum beats per line; must be ≤ 2**ADDR_WIDTH.

Ports (one clock; reset is asynchronous, active-low):
- pixel_clk  in  1  pixel clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  input pixel.
- s_axis_tvalid  in  1  input beat valid; no tready exists, so every valid beat must be consumed.
- s_axis_tuser  in  1  start of frame.
- s_axis_tlast  in  1  end of line.
- m_axis_tdata  out  DATA_WIDTH  output pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tuser  out  1  output SOF.
- m_axis_tlast  out  1  output end of line.
- m_axis_tready  in  1  downstream ready.
- fifo_level  out  ADDR_WIDTH+1  stored beats (RAM plus output register).
- drop_cnt  out  16  count of dropped lines; saturates at 16'hFFFF.
- line_err  out  1  one-cycle pulse when a line exceeds LINE_LEN.

## Operation
Storage:
- Each RAM word is {tuser, tlast, tdata}. The read side is first-word fall-through with a single registered output stage.
- A beat transfers when m_axis_tvalid & m_axis_tready.

Write-side state machine (states RESYNC, WAIT_SOL, ACCEPT, DROP):
- RESYNC (entered on reset): all beats are discarded.
  - A beat with tlast moves to WAIT_SOL.
  - A beat with tuser is evaluated as a line start, exactly as in WAIT_SOL.
- WAIT_SOL, on a valid beat:
  - If free = 2**ADDR_WIDTH − fifo_level ≥ LINE_LEN (level sampled in that cycle, before that cycle's read), the beat is written and the state moves to ACCEPT.
  - Otherwise the beat is discarded, drop_cnt increments, pending_sof |= s_axis_tuser, and the state moves to DROP.
  - A single-beat line (tlast on the first beat) stays in WAIT_SOL.
- ACCEPT: every valid beat is written. A beat counter (starts at 1 on the line's first beat) increments per beat.
  - tlast returns the state to WAIT_SOL.
  - If the counter reaches LINE_LEN without tlast, that beat is written with tlast forced to 1, line_err pulses, and the state moves to DROP.
- DROP: beats are discarded; pending_sof |= s_axis_tuser; tlast returns the state to WAIT_SOL.

SOF handling:
- The first written beat of an admitted line carries tuser = s_axis_tuser | pending_sof.
- pending_sof clears on that write.
- Mid-line tuser is passed through unchanged.

Invariant: admission guarantees the RAM never overflows, so no write is ever blocked by full.

## Timing
Reset values:
- All m_axis_* outputs are 0.
- fifo_level = 0, drop_cnt = 0, line_err = 0, pending_sof = 0.
- Pointers are 0 and the state is RESYNC.
- Reset asserted mid-line flushes all buffered data immediately; no partial output completes.

Latency:
- With an empty FIFO and m_axis_tready = 1, a beat sampled at edge k is presented on m_axis after edge k+2.
- Sustained throughput is 1 beat per clock.

Handshake:
- m_axis_tdata, tuser and tlast are stable while m_axis_tvalid = 1 and m_axis_tready = 0.
- m_axis_tvalid never drops without a transfer.

fifo_level:
- Increments on a write and decrements on a transfer.
- A simultaneous write and transfer leaves it unchanged.
- Range is 0..2**ADDR_WIDTH.

Other boundaries:
- Pointers wrap modulo 2**ADDR_WIDTH.
- drop_cnt holds at 16'hFFFF.
- line_err is registered and asserts in the cycle after the offending beat.

## Test plan
- **Basic flow:** after reset, a single beat with tlast, then 3 lines of 2048 beats (first beat tuser = 1, data = column index), tready = 1 → 3×2048 beats out in order, tuser only on beat 0, tlast on beats 2047/4095/6143; drop_cnt = 0; first output 2 cycles after first input.
- **Backpressure drop:** tready = 0 while 3 lines arrive → lines 1–2 stored (level 4096), line 3 dropped, drop_cnt = 1; release tready → exactly 4096 beats, 2 tlasts.
- **SOF preservation:** drop a line carrying tuser, then admit the next line (tuser = 0) → its first output beat has tuser = 1; later lines have tuser = 0.
- **Overlong line:** a 2050-beat line into an empty FIFO → 2048 beats out, tlast forced on beat 2047, line_err pulses once, the 2 excess beats are discarded, and the next line is admitted normally.
- **Resync:** release reset in the middle of a line (1000 beats remaining) → the whole partial line is discarded, and output starts with the next full line.
- **Async reset:** rst_n low for 1 cycle with level = 3000 → all outputs and fifo_level are 0 immediately and stay 0 until new input arrives.
